// File: rtl/riscv_mdu_ctrl_if.sv
// Handshake bundle between the execute stage and the MDU sequencing controller.
// The master side drives the EX-stage op; the slave side is the controller.
interface riscv_mdu_ctrl_if;
  logic       i_valid_e;
  logic       i_is_div_e;
  logic       i_div_zero_e;
  logic [4:0] i_rd_e;
  logic       i_kill;
  logic       o_start;
  logic       o_abort;
  logic       o_stall;
  logic       o_busy;
  logic       o_done;
  logic       o_is_div;
  logic [4:0] o_rd;

  modport master (
    output i_valid_e, i_is_div_e, i_div_zero_e, i_rd_e, i_kill,
    input  o_start, o_abort, o_stall, o_busy, o_done, o_is_div, o_rd
  );

  modport slave (
    input  i_valid_e, i_is_div_e, i_div_zero_e, i_rd_e, i_kill,
    output o_start, o_abort, o_stall, o_busy, o_done, o_is_div, o_rd
  );
endinterface

// File: rtl/riscv_mdu_ctrl.sv
// Multiply/divide sequencing controller: starts the MDU, stalls F/D/E for the
// op's fixed latency, then releases it to MEM with a one-cycle done strobe.
module riscv_mdu_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input logic              i_clk,
  input logic              i_rstn,
  riscv_mdu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             is_div_r, is_div_s;
  logic [4:0]       rd_r, rd_s;
  logic             start_s, abort_s, stall_s, done_s;

  // State, countdown and in-flight op tag registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      is_div_r <= 1'b0;
      rd_r     <= 5'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      is_div_r <= is_div_s;
      rd_r     <= rd_s;
    end
  end

  // Next-state and pulse/stall decode; i_rstn gates the IDLE accept so nothing fires in reset
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    is_div_s = is_div_r;
    rd_s     = rd_r;
    start_s  = 1'b0;
    abort_s  = 1'b0;
    stall_s  = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_rstn && bus.i_valid_e && !bus.i_kill) begin
          start_s  = 1'b1;
          stall_s  = 1'b1;
          state_s  = RUN;
          is_div_s = bus.i_is_div_e;
          rd_s     = bus.i_rd_e;
          if (bus.i_is_div_e && bus.i_div_zero_e) begin
            cnt_s = {CNT_W{1'b0}};
          end else if (bus.i_is_div_e) begin
            cnt_s = DIV_LOAD;
          end else begin
            cnt_s = MUL_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (bus.i_kill) begin
          abort_s = 1'b1;
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          stall_s = 1'b1;
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_s = cnt_r - CNT_W'(1);
          end else begin
            state_s = DONE;
          end
        end
      end
      DONE: begin
        // The finishing op still sits in EX here, so i_valid_e is deliberately ignored
        state_s = IDLE;
        if (bus.i_kill) begin
          abort_s = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          done_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign bus.o_start  = start_s;
  assign bus.o_abort  = abort_s;
  assign bus.o_stall  = stall_s;
  assign bus.o_done   = done_s;
  assign bus.o_busy   = (state_r != IDLE);
  assign bus.o_is_div = is_div_r;
  assign bus.o_rd     = rd_r;

endmodule
